uart_tx_fifo: RTL and testbench

- Byte FIFO that buffers bytes from a producer and feeds them one at a time into `uart_tx`.
- Issues `uart_tx`'s single-cycle `valid` launch pulse and waits for its `done` before launching the next byte.
- Sits directly upstream of `uart_tx`; its `tx_*` ports connect one-to-one to `uart_tx`'s `valid`/`data`/`ready`/`done`.
- Purpose: the producer can burst up to DEPTH bytes without tracking serial-line timing.

---
 rtl/uart_tx_fifo.sv | 113 +++++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers producer bytes and launches them one at a
// time with a single-cycle valid pulse, waiting for done before the next launch.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = reset & ~full & ~flush;
    assign busy     = (state_q == ST_LAUNCH) || (state_q == ST_BUSY);
    assign count    = count_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

    assign push = in_valid & in_ready;
    assign pop  = (state_q == ST_IDLE) & ~empty & tx_ready & ~flush;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flush only touches the queue; a byte already launched finishes untouched.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d    = ST_LAUNCH;
                    tx_valid_d = 1'b1;
                    tx_data_d  = mem_q[rp_q];
                end
            end
            ST_LAUNCH: state_d = ST_BUSY;
            ST_BUSY: begin
                if (tx_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural uart_tx model, byte scoreboard, fill table
// and hand-written sequences for launch/push overlap, flush and reset.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DLY   = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          flush;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          tx_done;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int launches = 0;
    int max_count = 0;
    logic [7:0] sb[$];
    logic [7:0] last_launched = 8'h00;
    logic       prev_vld = 1'b0;

    // uart_tx stand-in: busy from the launch edge, done pulse DLY+1 cycles later
    logic ready_en;
    logic m_busy;
    int   m_cnt;
    assign tx_ready = ready_en & ~m_busy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy  <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (tx_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= DLY;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected bytes enter the queue on the accepting edge; flush/reset empty it.
    always @(posedge clk or negedge reset) begin
        if (!reset) sb.delete();
        else if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(in_data);
    end

    always @(negedge clk) begin
        if (reset) begin
            if (tx_valid) begin
                launches++;
                chk("tx_valid_one_cycle", {31'd0, prev_vld}, 32'd0);
                if (sb.size() == 0) begin
                    chk("sb_unexpected_launch", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
                end
                last_launched = tx_data;
            end
            if (tx_done) chk("tx_data_held_to_done", {24'd0, tx_data}, {24'd0, last_launched});
            if (int'(count) > max_count) max_count = int'(count);
        end
        prev_vld = tx_valid;
    end

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k;
        k = 0;
        while (k < limit && !(!busy && empty && !m_busy)) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, (!busy && empty && !m_busy)}, 32'd1);
    endtask

    typedef struct {
        logic          vld;
        logic [7:0]    data;
        logic [CW-1:0] exp_count;
        logic          exp_full;
        logic          exp_in_ready;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int l0;
        for (int i = 0; i < 16; i++) begin
            tbl[i].vld          = 1'b1;
            tbl[i].data         = 8'(i);
            tbl[i].exp_count    = CW'(i + 1);
            tbl[i].exp_full     = (i == 15);
            tbl[i].exp_in_ready = (i != 15);
        end
        tbl[16].vld          = 1'b1;
        tbl[16].data         = 8'h10;
        tbl[16].exp_count    = CW'(16);
        tbl[16].exp_full     = 1'b1;
        tbl[16].exp_in_ready = 1'b0;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        flush    = 1'b0;
        ready_en = 1'b1;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        reset = 1'b1;
        #1;
        chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // single byte
        push_byte(8'hAB);
        chk("single_no_early_valid", {31'd0, tx_valid}, 32'd0);
        chk("single_count_after_push", {27'd0, count}, 32'd1);
        @(negedge clk);
        chk("single_valid", {31'd0, tx_valid}, 32'd1);
        chk("single_data", {24'd0, tx_data}, 32'hAB);
        chk("single_count_after_pop", {27'd0, count}, 32'd0);
        wait_idle(100, "single_done");
        chk("single_launches", launches, 32'd1);

        // fill with transmitter held off, then drain
        ready_en = 1'b0;
        l0 = launches;
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].vld;
            in_data  = tbl[i].data;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("fill_count", {27'd0, count}, {27'd0, tbl[i].exp_count});
            chk("fill_full", {31'd0, full}, {31'd0, tbl[i].exp_full});
            chk("fill_in_ready", {31'd0, in_ready}, {31'd0, tbl[i].exp_in_ready});
        end
        ready_en = 1'b1;
        wait_idle(16 * (DLY + 6) + 20, "fill_drain_done");
        chk("fill_drain_launches", launches - l0, 32'd16);
        chk("fill_drain_empty", {31'd0, empty}, 32'd1);

        // wrap-around
        l0 = launches;
        max_count = 0;
        ready_en = 1'b0;
        for (int i = 0; i < 10; i++) push_byte(8'($urandom_range(0, 255)));
        ready_en = 1'b1;
        wait_idle(10 * (DLY + 6) + 20, "wrap_drain1");
        ready_en = 1'b0;
        for (int i = 0; i < 12; i++) push_byte(8'($urandom_range(0, 255)));
        chk("wrap_count12", {27'd0, count}, 32'd12);
        ready_en = 1'b1;
        wait_idle(12 * (DLY + 6) + 20, "wrap_drain2");
        chk("wrap_launches", launches - l0, 32'd22);
        chk("wrap_max_count", {31'd0, (max_count <= DEPTH)}, 32'd1);

        // push in the launch cycle at count 3
        l0 = launches;
        ready_en = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'h31 + 8'(i));
        chk("pp3_count_before", {27'd0, count}, 32'd3);
        ready_en = 1'b1;
        push_byte(8'h34);
        chk("pp3_count_kept", {27'd0, count}, 32'd3);
        chk("pp3_launched", {31'd0, tx_valid}, 32'd1);
        wait_idle(4 * (DLY + 6) + 20, "pp3_drain");
        chk("pp3_launches", launches - l0, 32'd4);

        // push in the launch cycle while full is rejected
        l0 = launches;
        ready_en = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        chk("pp16_full", {31'd0, full}, 32'd1);
        ready_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        chk("pp16_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp16_count", {27'd0, count}, 32'd15);
        chk("pp16_launched", {31'd0, tx_valid}, 32'd1);
        wait_idle(16 * (DLY + 6) + 20, "pp16_drain");
        chk("pp16_launches", launches - l0, 32'd16);

        // flush while a byte is in flight
        ready_en = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        l0 = launches;
        ready_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        chk("flush_count_before", {27'd0, count}, 32'd4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", {27'd0, count}, 32'd0);
        chk("flush_empty", {31'd0, empty}, 32'd1);
        chk("flush_busy_kept", {31'd0, busy}, 32'd1);
        chk("flush_tx_data_kept", {24'd0, tx_data}, 32'h50);
        wait_idle(DLY + 20, "flush_inflight_done");
        repeat (30) @(negedge clk);
        chk("flush_no_more_launch", launches - l0, 32'd1);

        // reset mid-transmission
        ready_en = 1'b0;
        for (int i = 0; i < 2; i++) push_byte(8'h60 + 8'(i));
        ready_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", {27'd0, count}, 32'd0);
        chk("midrst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_idle_after", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
